// File: rtl/rv_timer_dispatch_pkg.sv
// rv_timer_dispatch_pkg: shared state encoding and miss-counter constants for the timer interrupt dispatcher
package rv_timer_dispatch_pkg;
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StHold = 2'b10
  } dispatch_state_e;
  localparam int MissCntW = 8;
  localparam logic [MissCntW-1:0] MissCntMax = {MissCntW{1'b1}};
endpackage

// File: rtl/rv_timer_dispatch_lane.sv
// rv_timer_dispatch_lane: one hart's edge detect, pending flag, req/ack FSM, holdoff and optional miss counter
// Ports: clk_i/rst_ni (async active-low), intr_i timer level, en_i dispatch enable, holdoff_i idle cycles
//        after ack, ack_i hart accept, req_o request; miss_clr_i/miss_cnt_o only with RV_TIMER_DISPATCH_MISSCNT_EN
module rv_timer_dispatch_lane
  import rv_timer_dispatch_pkg::*;
#(
  parameter int HoldoffW = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                intr_i,
  input  logic                en_i,
  input  logic [HoldoffW-1:0] holdoff_i,
  input  logic                ack_i,
  output logic                req_o
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
  ,
  input  logic                miss_clr_i,
  output logic [MissCntW-1:0] miss_cnt_o
`endif
);
  dispatch_state_e state_q, state_d;
  logic [HoldoffW-1:0] cnt_q, cnt_d;
  logic intr_q, pending_q, pending_d, rise, ack_ok, pend_now;
  always_comb begin
    rise      = intr_i & ~intr_q;
    ack_ok    = state_q == StReq && en_i && ack_i;
    pend_now  = pending_q | rise;
    // a new edge in the ack cycle keeps the event pending
    pending_d = rise | (pending_q & ~ack_ok);
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: state_d = pend_now && en_i ? StReq : StIdle;
      StReq: begin
        if (!en_i) state_d = StIdle;
        else if (ack_i) begin
          state_d = holdoff_i == '0 ? StIdle : StHold;
          cnt_d   = holdoff_i;
        end
      end
      StHold: begin
        cnt_d = cnt_q - 1'b1;
        // last holdoff cycle goes straight to REQ so the idle gap is exactly holdoff_i
        if (cnt_q == HoldoffW'(1)) state_d = pend_now && en_i ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      intr_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      intr_q    <= intr_i;
      pending_q <= pending_d;
    end
  end
  assign req_o = state_q == StReq;
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
  logic [MissCntW-1:0] miss_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) miss_q <= '0;
    else miss_q <= miss_clr_i ? '0 :
                   (rise && pending_q && !ack_ok && miss_q != MissCntMax) ? miss_q + 1'b1 : miss_q;
  end
  assign miss_cnt_o = miss_q;
`endif
endmodule

// File: rtl/rv_timer_intr_dispatch.sv
// rv_timer_intr_dispatch: delivers per-hart rv_timer expiry levels to harts over independent req/ack lanes
// Ports: clk_i/rst_ni (async active-low), intr_timer_i[NHarts] expiry levels, en_i[NHarts] enables,
//        holdoff_i shared post-ack idle cycles, irq_ack_i/irq_req_o per-hart handshake;
//        miss_clr_i[NHarts]/miss_cnt_o[NHarts*8] present only with RV_TIMER_DISPATCH_MISSCNT_EN
module rv_timer_intr_dispatch
  import rv_timer_dispatch_pkg::*;
#(
  parameter int NHarts   = 2,
  parameter int HoldoffW = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NHarts-1:0]          intr_timer_i,
  input  logic [NHarts-1:0]          en_i,
  input  logic [HoldoffW-1:0]        holdoff_i,
  input  logic [NHarts-1:0]          irq_ack_i,
  output logic [NHarts-1:0]          irq_req_o
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
  ,
  input  logic [NHarts-1:0]          miss_clr_i,
  output logic [NHarts*MissCntW-1:0] miss_cnt_o
`endif
);
  for (genvar g = 0; g < NHarts; g++) begin : g_lane
    rv_timer_dispatch_lane #(.HoldoffW(HoldoffW)) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .intr_i    (intr_timer_i[g]),
      .en_i      (en_i[g]),
      .holdoff_i (holdoff_i),
      .ack_i     (irq_ack_i[g]),
      .req_o     (irq_req_o[g])
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
      ,
      .miss_clr_i(miss_clr_i[g]),
      .miss_cnt_o(miss_cnt_o[g*MissCntW +: MissCntW])
`endif
    );
  end
endmodule

// File: tb/tb_rv_timer_intr_dispatch.sv
// tb_rv_timer_intr_dispatch: table-driven and sequence checks of the timer interrupt dispatcher
module tb_rv_timer_intr_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] intr = '0, en = '0, ack = '0, req;
  logic [7:0] holdoff = '0;
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
  logic [1:0] miss_clr = '0;
  logic [15:0] miss_cnt;
`endif
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [1:0] intr;
    logic [1:0] en;
    logic [1:0] ack;
    logic [7:0] ho;
    logic [1:0] req;
  } vec_t;
  typedef struct {
    string      name;
    logic [1:0] req;
  } exp_t;
  vec_t tbl[29];
  exp_t sb[$];

  always #5 clk = ~clk;

  rv_timer_intr_dispatch #(.NHarts(2), .HoldoffW(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .intr_timer_i(intr),
    .en_i        (en),
    .holdoff_i   (holdoff),
    .irq_ack_i   (ack),
    .irq_req_o   (req)
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
    ,
    .miss_clr_i  (miss_clr),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, queue the req expected after the edge, then compare
  task automatic step(input logic [1:0] i_intr, input logic [1:0] i_en, input logic [1:0] i_ack,
                      input logic [7:0] i_ho, input logic [1:0] e_req, input string name);
    exp_t e;
    intr = i_intr;
    en = i_en;
    ack = i_ack;
    holdoff = i_ho;
    sb.push_back('{name, e_req});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, {14'd0, req}, {14'd0, e.req});
  endtask

  initial begin
    tbl[0]  = '{2'b00, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[1]  = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b01};
    tbl[2]  = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b01};
    tbl[3]  = '{2'b01, 2'b11, 2'b01, 8'd4, 2'b00};
    tbl[4]  = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[5]  = '{2'b01, 2'b11, 2'b11, 8'd4, 2'b00};
    tbl[6]  = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[7]  = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[8]  = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[9]  = '{2'b00, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[10] = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b01};
    tbl[11] = '{2'b01, 2'b11, 2'b01, 8'd4, 2'b00};
    tbl[12] = '{2'b00, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[13] = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[14] = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b00};
    tbl[15] = '{2'b01, 2'b11, 2'b00, 8'd4, 2'b01};
    tbl[16] = '{2'b01, 2'b11, 2'b01, 8'd0, 2'b00};
    tbl[17] = '{2'b00, 2'b11, 2'b00, 8'd0, 2'b00};
    tbl[18] = '{2'b01, 2'b11, 2'b00, 8'd0, 2'b01};
    tbl[19] = '{2'b00, 2'b11, 2'b00, 8'd0, 2'b01};
    tbl[20] = '{2'b01, 2'b11, 2'b01, 8'd0, 2'b00};
    tbl[21] = '{2'b01, 2'b11, 2'b00, 8'd0, 2'b01};
    tbl[22] = '{2'b01, 2'b11, 2'b01, 8'd0, 2'b00};
    tbl[23] = '{2'b00, 2'b11, 2'b00, 8'd0, 2'b00};
    tbl[24] = '{2'b01, 2'b11, 2'b00, 8'd0, 2'b01};
    tbl[25] = '{2'b01, 2'b10, 2'b00, 8'd0, 2'b00};
    tbl[26] = '{2'b00, 2'b10, 2'b00, 8'd0, 2'b00};
    tbl[27] = '{2'b00, 2'b11, 2'b00, 8'd0, 2'b01};
    tbl[28] = '{2'b00, 2'b11, 2'b01, 8'd0, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", {14'd0, req}, 16'd0);
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
    chk("reset_miss", miss_cnt, 16'd0);
`endif
    rst_n = 1'b1;

    // holdoff, edge during holdoff, ack+edge collision, enable drop in REQ
    for (int i = 0; i < 29; i++)
      step(tbl[i].intr, tbl[i].en, tbl[i].ack, tbl[i].ho, tbl[i].req, $sformatf("tbl%0d", i));
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
    chk("miss_after_tbl", miss_cnt, 16'd0);
`endif

    // three edges with hart 0 disabled
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 2'b10, 2'b00, 8'd0, 2'b00, $sformatf("dis_hi%0d", i));
      step(2'b00, 2'b10, 2'b00, 8'd0, 2'b00, $sformatf("dis_lo%0d", i));
    end
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
    chk("miss_two", miss_cnt, 16'h0002);
`endif
    step(2'b00, 2'b11, 2'b00, 8'd0, 2'b01, "en_raise");
    step(2'b00, 2'b11, 2'b01, 8'd0, 2'b00, "en_ack");
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
    miss_clr = 2'b01;
    step(2'b00, 2'b11, 2'b00, 8'd0, 2'b00, "clr_cycle");
    miss_clr = 2'b00;
    chk("miss_cleared", miss_cnt, 16'd0);
    for (int i = 0; i < 300; i++) begin
      step(2'b01, 2'b10, 2'b00, 8'd0, 2'b00, "sat_hi");
      step(2'b00, 2'b10, 2'b00, 8'd0, 2'b00, "sat_lo");
    end
    chk("miss_sat", miss_cnt, 16'h00ff);
    miss_clr = 2'b01;
    step(2'b01, 2'b10, 2'b00, 8'd0, 2'b00, "clr_vs_inc");
    miss_clr = 2'b00;
    chk("miss_clr_wins", miss_cnt, 16'd0);
`endif

    // both lanes into REQ, then async reset mid-handshake
    step(2'b00, 2'b10, 2'b00, 8'd4, 2'b00, "pre_rst_lo");
    step(2'b11, 2'b10, 2'b00, 8'd4, 2'b10, "pre_rst_h1");
    step(2'b11, 2'b11, 2'b00, 8'd4, 2'b11, "pre_rst_both");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {14'd0, req}, 16'd0);
`ifdef RV_TIMER_DISPATCH_MISSCNT_EN
    chk("async_rst_miss", miss_cnt, 16'd0);
`endif
    intr = 2'b01;
    @(posedge clk);
    #1;
    chk("in_rst_req", {14'd0, req}, 16'd0);
    rst_n = 1'b1;
    step(2'b01, 2'b11, 2'b00, 8'd4, 2'b01, "rel_high_edge");
    step(2'b11, 2'b11, 2'b01, 8'd4, 2'b10, "lane_indep");
    step(2'b10, 2'b11, 2'b10, 8'd0, 2'b00, "lane_indep_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
